// File: rtl/mips_core_pkg.sv
// Shared core types plus perceptron branch predictor defaults and helpers.
package mips_core_pkg;

    localparam int ADDR_WIDTH = 32;

    typedef enum logic {
        NOT_TAKEN = 1'b0,
        TAKEN     = 1'b1
    } BranchOutcome;

    // Default perceptron predictor geometry
    localparam int BP_INDEX_BITS  = 4;
    localparam int BP_HIST_LEN    = 8;
    localparam int BP_WEIGHT_BITS = 8;

    // Training threshold floor(1.93*HIST_LEN + 14), kept in integer arithmetic
    localparam int BP_THETA = (193 * BP_HIST_LEN) / 100 + 14;

    // Add delta to a signed weight and clamp to the two's complement range of width bits
    function automatic int bp_sat_add(input int value, input int delta, input int width);
        int sum;
        int max_v;
        int min_v;
        sum   = value + delta;
        max_v = (1 << (width - 1)) - 1;
        min_v = -(1 << (width - 1));
        if (sum > max_v) begin
            return max_v;
        end
        if (sum < min_v) begin
            return min_v;
        end
        return sum;
    endfunction

endpackage

// File: rtl/perceptron_predictor_pipelined_dot_product.sv
// Combinational perceptron output: bias plus history-signed sum of weights.
module perceptron_dot_product
    import mips_core_pkg::*;
#(
    parameter int HIST_LEN    = BP_HIST_LEN,
    parameter int WEIGHT_BITS = BP_WEIGHT_BITS,
    parameter int Y_BITS      = BP_WEIGHT_BITS + $clog2(BP_HIST_LEN + 2)
) (
    input  logic [HIST_LEN:0][WEIGHT_BITS-1:0] i_weights,
    input  logic [HIST_LEN-1:0]                i_hist,
    output logic signed [Y_BITS-1:0]           o_y
);

    logic signed [Y_BITS-1:0] w_acc;
    logic signed [Y_BITS-1:0] w_term;

    // Accumulate w0 and then add or subtract each wi depending on its history bit
    always_comb begin
        w_acc  = {{(Y_BITS-WEIGHT_BITS){i_weights[0][WEIGHT_BITS-1]}}, i_weights[0]};
        w_term = '0;
        for (int i = 1; i <= HIST_LEN; i++) begin
            w_term = {{(Y_BITS-WEIGHT_BITS){i_weights[i][WEIGHT_BITS-1]}}, i_weights[i]};
            if (i_hist[i-1]) begin
                w_acc = w_acc + w_term;
            end else begin
                w_acc = w_acc - w_term;
            end
        end
    end

    assign o_y = w_acc;

endmodule

// File: rtl/perceptron_predictor_pipelined.sv
// Perceptron branch predictor: same-cycle prediction, 2-stage training pipeline.
module perceptron_predictor_pipelined
    import mips_core_pkg::*;
#(
    parameter int INDEX_BITS  = BP_INDEX_BITS,
    parameter int HIST_LEN    = BP_HIST_LEN,
    parameter int WEIGHT_BITS = BP_WEIGHT_BITS,
    parameter int THETA       = BP_THETA,
    parameter int COUNT_BITS  = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_req_valid,
    input  logic [ADDR_WIDTH-1:0] i_req_pc,
    input  logic [ADDR_WIDTH-1:0] i_req_target,
    output BranchOutcome          o_req_prediction,
    input  logic                  i_fb_valid,
    input  logic [ADDR_WIDTH-1:0] i_fb_pc,
    input  BranchOutcome          i_fb_prediction,
    input  BranchOutcome          i_fb_outcome,
    output logic [COUNT_BITS-1:0] o_pred_count,
    output logic [COUNT_BITS-1:0] o_miss_count
);

    localparam int ENTRIES = 1 << INDEX_BITS;
    localparam int Y_BITS  = WEIGHT_BITS + $clog2(HIST_LEN + 2);
    localparam logic signed [Y_BITS-1:0] THETA_POS = Y_BITS'(THETA);
    localparam logic signed [Y_BITS-1:0] THETA_NEG = Y_BITS'(-THETA);

    typedef logic [HIST_LEN:0][WEIGHT_BITS-1:0] row_t;

    row_t                     r_table [ENTRIES];
    logic [HIST_LEN-1:0]      r_ghr;
    logic                     r_s1_valid;
    logic [INDEX_BITS-1:0]    r_s1_idx;
    BranchOutcome             r_s1_outcome;
    logic [HIST_LEN-1:0]      r_s1_hist;
    logic [COUNT_BITS-1:0]    r_pred_count;
    logic [COUNT_BITS-1:0]    r_miss_count;

    logic [INDEX_BITS-1:0]    w_req_idx;
    logic [INDEX_BITS-1:0]    w_fb_idx;
    row_t                     w_req_row;
    row_t                     w_fb_row;
    row_t                     w_new_row;
    logic [HIST_LEN:0]        w_x;
    logic signed [Y_BITS-1:0] w_req_y;
    logic signed [Y_BITS-1:0] w_fb_y;
    logic                     w_sign_wrong;
    logic                     w_low_conf;
    logic                     w_train;
    logic                     w_unused;

    // The request is stateless, the target is only kept for port compatibility and
    // upper PC bits alias into the table on purpose.
    assign w_unused = ^{i_req_valid, i_req_target, i_req_pc, i_fb_pc};

    assign w_req_idx = i_req_pc[INDEX_BITS+1:2];
    assign w_fb_idx  = i_fb_pc[INDEX_BITS+1:2];
    assign w_req_row = r_table[w_req_idx];
    // The table is flops read combinationally, so a row written at the previous edge
    // is already visible here: back-to-back training to one index is cumulative.
    assign w_fb_row  = r_table[r_s1_idx];

    perceptron_dot_product #(
        .HIST_LEN    (HIST_LEN),
        .WEIGHT_BITS (WEIGHT_BITS),
        .Y_BITS      (Y_BITS)
    ) u_pred_dot (
        .i_weights (w_req_row),
        .i_hist    (r_ghr),
        .o_y       (w_req_y)
    );

    perceptron_dot_product #(
        .HIST_LEN    (HIST_LEN),
        .WEIGHT_BITS (WEIGHT_BITS),
        .Y_BITS      (Y_BITS)
    ) u_train_dot (
        .i_weights (w_fb_row),
        .i_hist    (r_s1_hist),
        .o_y       (w_fb_y)
    );

    assign o_req_prediction = w_req_y[Y_BITS-1] ? NOT_TAKEN : TAKEN;

    // Train when the recomputed sign disagrees with the outcome or confidence is low
    always_comb begin
        w_sign_wrong = (~w_fb_y[Y_BITS-1]) != (r_s1_outcome == TAKEN);
        w_low_conf   = (w_fb_y <= THETA_POS) && (w_fb_y >= THETA_NEG);
        w_train      = w_sign_wrong || w_low_conf;
    end

    // Move each weight one step toward t*xi, with x0 the constant bias input
    always_comb begin
        w_x       = {r_s1_hist, 1'b1};
        w_new_row = w_fb_row;
        for (int i = 0; i <= HIST_LEN; i++) begin
            w_new_row[i] = WEIGHT_BITS'(bp_sat_add(int'($signed(w_fb_row[i])),
                                                   (w_x[i] == (r_s1_outcome == TAKEN)) ? 1 : -1,
                                                   WEIGHT_BITS));
        end
    end

    // Stage 2: clear the table on reset, otherwise write back the trained row
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int e = 0; e < ENTRIES; e++) begin
                r_table[e] <= '0;
            end
        end else if (r_s1_valid && w_train) begin
            r_table[r_s1_idx] <= w_new_row;
        end
    end

    // Stage 1: snapshot feedback with the pre-update history, then shift the outcome in
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_s1_valid   <= 1'b0;
            r_s1_idx     <= '0;
            r_s1_outcome <= NOT_TAKEN;
            r_s1_hist    <= '0;
            r_ghr        <= '0;
        end else begin
            r_s1_valid <= i_fb_valid;
            if (i_fb_valid) begin
                r_s1_idx     <= w_fb_idx;
                r_s1_outcome <= i_fb_outcome;
                r_s1_hist    <= r_ghr;
                r_ghr        <= {r_ghr[HIST_LEN-2:0], i_fb_outcome == TAKEN};
            end
        end
    end

    // Saturating counters for resolved branches and mispredictions
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pred_count <= '0;
            r_miss_count <= '0;
        end else if (i_fb_valid) begin
            if (r_pred_count != '1) begin
                r_pred_count <= r_pred_count + COUNT_BITS'(1);
            end
            if ((i_fb_prediction != i_fb_outcome) && (r_miss_count != '1)) begin
                r_miss_count <= r_miss_count + COUNT_BITS'(1);
            end
        end
    end

    assign o_pred_count = r_pred_count;
    assign o_miss_count = r_miss_count;

endmodule

// File: tb/tb_perceptron_predictor_pipelined.sv
// Directed self-checking bench for the perceptron predictor (4-bit counters).
module tb_perceptron_predictor_pipelined;
    import mips_core_pkg::*;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic                  i_req_valid;
    logic [ADDR_WIDTH-1:0] i_req_pc;
    logic [ADDR_WIDTH-1:0] i_req_target;
    BranchOutcome          o_req_prediction;
    logic                  i_fb_valid;
    logic [ADDR_WIDTH-1:0] i_fb_pc;
    BranchOutcome          i_fb_prediction;
    BranchOutcome          i_fb_outcome;
    logic [3:0]            o_pred_count;
    logic [3:0]            o_miss_count;

    int errors = 0;
    int checks = 0;

    // Free-running clock, 10 time units per period
    always #5 clk = ~clk;

    perceptron_predictor_pipelined #(
        .COUNT_BITS (4)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .i_req_valid      (i_req_valid),
        .i_req_pc         (i_req_pc),
        .i_req_target     (i_req_target),
        .o_req_prediction (o_req_prediction),
        .i_fb_valid       (i_fb_valid),
        .i_fb_pc          (i_fb_pc),
        .i_fb_prediction  (i_fb_prediction),
        .i_fb_outcome     (i_fb_outcome),
        .o_pred_count     (o_pred_count),
        .o_miss_count     (o_miss_count)
    );

    task automatic checkOutput(input string tag, input logic signed [31:0] observed,
                               input logic signed [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic fbValid, input logic [31:0] fbPc,
                                 input BranchOutcome fbPred, input BranchOutcome fbOut);
        i_fb_valid      = fbValid;
        i_fb_pc         = fbPc;
        i_fb_prediction = fbPred;
        i_fb_outcome    = fbOut;
        tick();
        i_fb_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        i_fb_valid = 1'b0;
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic doReset();
        rst_n      = 1'b0;
        i_fb_valid = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic checkPrediction(input string tag, input logic [31:0] pc,
                                   input BranchOutcome expected);
        i_req_pc = pc;
        #1;
        checkOutput(tag, o_req_prediction, expected);
    endtask

    initial begin
        BranchOutcome p;
        BranchOutcome outc;
        int wrongLate;
        logic [3:0] missBefore;

        rst_n           = 1'b0;
        i_req_valid     = 1'b1;
        i_req_pc        = '0;
        i_req_target    = 32'h0000_1000;
        i_fb_valid      = 1'b0;
        i_fb_pc         = '0;
        i_fb_prediction = TAKEN;
        i_fb_outcome    = TAKEN;
        wrongLate       = 0;
        missBefore      = '0;

        // Reset state, then three not-taken trainings on pc 0x40
        doReset();
        checkPrediction("reset_pred", 32'h44, TAKEN);
        checkOutput("reset_pred_count", o_pred_count, 0);
        checkOutput("reset_miss_count", o_miss_count, 0);
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 32'h40, TAKEN, NOT_TAKEN);
        idle(2);
        checkOutput("nt3_w0", $signed(dut.r_table[0][0]), -3);
        checkOutput("nt3_w1", $signed(dut.r_table[0][1]), 3);
        checkPrediction("nt3_pred", 32'h40, NOT_TAKEN);
        checkOutput("nt3_pred_count", o_pred_count, 3);
        checkOutput("nt3_miss_count", o_miss_count, 3);

        // Five back-to-back taken beats on one pc train cumulatively
        doReset();
        for (int i = 0; i < 5; i++) applyStimulus(1'b1, 32'h80, TAKEN, TAKEN);
        idle(2);
        checkOutput("b2b_w0", $signed(dut.r_table[0][0]), 5);
        checkOutput("b2b_w1", $signed(dut.r_table[0][1]), 3);
        checkOutput("b2b_w8", $signed(dut.r_table[0][8]), -5);
        checkOutput("b2b_pred_count", o_pred_count, 5);
        checkOutput("b2b_miss_count", o_miss_count, 0);

        // 200 taken beats: training stops past theta, counters saturate
        doReset();
        for (int i = 0; i < 200; i++) applyStimulus(1'b1, 32'h80, NOT_TAKEN, TAKEN);
        idle(2);
        checkOutput("theta_w0", $signed(dut.r_table[0][0]), 12);
        checkOutput("theta_w1", $signed(dut.r_table[0][1]), 10);
        checkOutput("theta_w8", $signed(dut.r_table[0][8]), -4);
        checkPrediction("theta_pred", 32'h80, TAKEN);
        checkOutput("sat_pred_count", o_pred_count, 15);
        checkOutput("sat_miss_count", o_miss_count, 15);

        // Alternating pattern fed back with the predictor's own predictions
        doReset();
        i_req_pc = 32'h100;
        for (int k = 0; k < 100; k++) begin
            outc = (k % 2 == 0) ? TAKEN : NOT_TAKEN;
            #1;
            p = o_req_prediction;
            if (k == 80) missBefore = o_miss_count;
            if (k >= 80 && p != outc) wrongLate++;
            i_fb_valid      = 1'b1;
            i_fb_pc         = 32'h100;
            i_fb_prediction = p;
            i_fb_outcome    = outc;
            tick();
        end
        idle(2);
        checkOutput("alt_late_wrong", wrongLate, 0);
        checkOutput("alt_miss_stable", o_miss_count, missBefore);

        // A request at the write edge sees old weights, the next cycle sees new ones
        doReset();
        applyStimulus(1'b1, 32'h40, TAKEN, NOT_TAKEN);
        checkPrediction("collide_old", 32'h40, TAKEN);
        tick();
        checkPrediction("collide_new", 32'h40, NOT_TAKEN);
        checkOutput("collide_w0", $signed(dut.r_table[0][0]), -1);

        // Reset while a feedback sits in stage 1: nothing is written afterwards
        doReset();
        applyStimulus(1'b1, 32'h40, TAKEN, NOT_TAKEN);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        idle(2);
        checkOutput("midrst_w0", $signed(dut.r_table[0][0]), 0);
        checkOutput("midrst_w1", $signed(dut.r_table[0][1]), 0);
        checkPrediction("midrst_pred", 32'h40, TAKEN);
        checkOutput("midrst_pred_count", o_pred_count, 0);
        checkOutput("midrst_miss_count", o_miss_count, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
